// File: rtl/rvfi_retire_stats_pkg.sv
// rvfi_stats_pkg: shared definitions for the RVFI retirement statistics block.
//   cnt_idx_e  - counter index, also the encoding used on the rd_sel read port
//   NUM_CNT    - number of live counters (indices 6 and 7 read as zero)
//   OPC_LONG   - insn[1:0] value marking an uncompressed 32-bit instruction
//   cnt_evt_t  - per-counter increment strobes, indexed by cnt_idx_e
package rvfi_stats_pkg;

    typedef enum logic [2:0] {
        TOTAL  = 3'd0,
        DMEMRD = 3'd1,
        DMEMWR = 3'd2,
        LONG   = 3'd3,
        COMPR  = 3'd4,
        TRAP   = 3'd5
    } cnt_idx_e;

    localparam int unsigned NUM_CNT  = 6;
    localparam logic [1:0]  OPC_LONG = 2'b11;

    typedef logic [NUM_CNT-1:0] cnt_evt_t;

endpackage

// File: rtl/rvfi_retire_stats_sat_counter.sv
// rvfi_sat_counter: W-bit event counter that sticks at all-ones.
//   clk, reset_n - clock, asynchronous active-low reset
//   inc          - count one event this cycle
//   clr          - synchronous clear, wins over inc
//   cnt          - registered count
module rvfi_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/rvfi_retire_stats.sv
// rvfi_retire_stats: passive observer of the RVFI retirement stream.
// Classifies each retired instruction, keeps saturating per-class counters,
// a snapshot bank readable through a one-cycle-latency read port, and a
// sticky flag once every memory/length class has reached GOAL events.
//   clk, reset_n           - clock, asynchronous active-low reset
//   rvfi_valid/insn/trap   - retirement strobe, instruction word, trap flag
//   rvfi_mem_rmask/wmask   - data read / write byte masks
//   clear                  - synchronous clear of counters, snapshot, goal_hit
//   snap                   - copy live counters into the snapshot bank
//   rd_req, rd_sel         - read request and counter index (cnt_idx_e)
//   rd_ack, rd_data        - one-cycle read response pulse and data
//   goal_hit               - sticky coverage goal
module rvfi_retire_stats
    import rvfi_stats_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned GOAL  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rvfi_valid,
    input  logic [31:0]      rvfi_insn,
    input  logic             rvfi_trap,
    input  logic [3:0]       rvfi_mem_rmask,
    input  logic [3:0]       rvfi_mem_wmask,
    input  logic             clear,
    input  logic             snap,
    input  logic             rd_req,
    input  logic [2:0]       rd_sel,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data,
    output logic             goal_hit
);

    typedef logic [CNT_W-1:0] bank_t [NUM_CNT];

    localparam logic [CNT_W-1:0] GOAL_C = CNT_W'(GOAL);

    cnt_evt_t         evt;
    bank_t            live;
    bank_t            snap_q;
    bank_t            snap_d;
    logic             goal_all;
    logic             goal_q;
    logic             goal_d;
    logic [CNT_W-1:0] rd_val;
    logic             rd_ack_q;
    logic             rd_ack_d;
    logic [CNT_W-1:0] rd_data_q;
    logic [CNT_W-1:0] rd_data_d;

    // Event decode; trapped instructions never count as memory accesses.
    always_comb begin
        evt = '0;
        if (rvfi_valid) begin
            evt[TOTAL]  = 1'b1;
            evt[TRAP]   = rvfi_trap;
            evt[LONG]   = (rvfi_insn[1:0] == OPC_LONG);
            evt[COMPR]  = (rvfi_insn[1:0] != OPC_LONG);
            evt[DMEMRD] = (|rvfi_mem_rmask) && !rvfi_trap;
            evt[DMEMWR] = (|rvfi_mem_wmask) && !rvfi_trap;
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        rvfi_sat_counter #(
            .W(CNT_W)
        ) u_cnt (
            .clk    (clk),
            .reset_n(reset_n),
            .inc    (evt[g]),
            .clr    (clear),
            .cnt    (live[g])
        );
    end

    // Snapshot takes the registered counts, so a same-cycle event is excluded.
    always_comb begin
        snap_d = snap_q;
        if (clear) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                snap_d[i] = '0;
            end
        end else if (snap) begin
            snap_d = live;
        end
    end

    assign goal_all = (live[DMEMRD] >= GOAL_C) && (live[DMEMWR] >= GOAL_C) &&
                      (live[LONG]   >= GOAL_C) && (live[COMPR]  >= GOAL_C);

    assign goal_d = clear ? 1'b0 : (goal_q | goal_all);

    // Indices past the last counter read as zero.
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (rd_sel == 3'(i)) begin
                rd_val = snap_q[i];
            end
        end
    end

    assign rd_ack_d  = rd_req;
    assign rd_data_d = rd_req ? rd_val : rd_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_q    <= '{default: '0};
            goal_q    <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            snap_q    <= snap_d;
            goal_q    <= goal_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_ack   = rd_ack_q;
    assign rd_data  = rd_data_q;
    assign goal_hit = goal_q;

endmodule

// File: tb/tb_rvfi_retire_stats.sv
module tb_rvfi_retire_stats;
    import rvfi_stats_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rvfi_valid;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap;
    logic [3:0]  rvfi_mem_rmask;
    logic [3:0]  rvfi_mem_wmask;
    logic        clear;
    logic        snap;
    logic        rd_req;
    logic [2:0]  rd_sel;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        goal_hit;
    logic        rd_ack4;
    logic [3:0]  rd_data4;
    logic        goal_hit4;

    always #5 clk = ~clk;

    rvfi_retire_stats #(.CNT_W(16), .GOAL(2)) dut (
        .clk(clk), .reset_n(reset_n), .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .clear(clear), .snap(snap), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_ack(rd_ack), .rd_data(rd_data), .goal_hit(goal_hit)
    );

    rvfi_retire_stats #(.CNT_W(4), .GOAL(2)) dut4 (
        .clk(clk), .reset_n(reset_n), .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .clear(clear), .snap(snap), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_ack(rd_ack4), .rd_data(rd_data4), .goal_hit(goal_hit4)
    );

    int unsigned checks = 0;
    int unsigned passed = 0;

    // Reference model: unbounded event counts since the last clear/reset.
    int unsigned m_cnt [6];
    int unsigned m_snap[6];
    bit          m_goal;
    bit          m_ack;
    int unsigned m_rd;

    localparam logic [31:0] I_LOAD  = 32'h0000_2083;
    localparam logic [31:0] I_STORE = 32'h0000_A023;
    localparam logic [31:0] I_COMPR = 32'h0000_4501;
    localparam logic [31:0] I_ADDI  = 32'h0000_0013;

    function automatic int unsigned sat(input int unsigned v, input int unsigned w);
        int unsigned mx = (32'd1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_cnt[i]  = 0;
            m_snap[i] = 0;
        end
        m_goal = 0;
        m_ack  = 0;
        m_rd   = 0;
    endtask

    // One clock: drive at negedge, update model at posedge, return at next negedge.
    task automatic drive_cycle(input bit v, input logic [31:0] insn, input bit trap,
                               input logic [3:0] rm, input logic [3:0] wm,
                               input bit clr, input bit snp, input bit rq, input logic [2:0] sel);
        bit reached;
        rvfi_valid = v; rvfi_insn = insn; rvfi_trap = trap;
        rvfi_mem_rmask = rm; rvfi_mem_wmask = wm;
        clear = clr; snap = snp; rd_req = rq; rd_sel = sel;
        @(posedge clk);
        reached = (m_cnt[DMEMRD] >= 2) && (m_cnt[DMEMWR] >= 2) &&
                  (m_cnt[LONG] >= 2) && (m_cnt[COMPR] >= 2);
        m_ack = rq;
        if (rq) m_rd = (sel < 6) ? m_snap[sel] : 0;
        if (clr) begin
            for (int i = 0; i < 6; i++) begin
                m_cnt[i]  = 0;
                m_snap[i] = 0;
            end
            m_goal = 0;
        end else begin
            if (snp) m_snap = m_cnt;
            if (v) begin
                m_cnt[TOTAL]++;
                if (trap) m_cnt[TRAP]++;
                if (insn[1:0] == 2'b11) m_cnt[LONG]++;
                else m_cnt[COMPR]++;
                if (rm != 0 && !trap) m_cnt[DMEMRD]++;
                if (wm != 0 && !trap) m_cnt[DMEMWR]++;
            end
            m_goal = m_goal | reached;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive_cycle(0, '0, 0, '0, '0, 0, 0, 0, '0);
    endtask

    task automatic retire(input logic [31:0] insn, input logic [3:0] rm, input logic [3:0] wm, input bit trap);
        drive_cycle(1, insn, trap, rm, wm, 0, 0, 0, '0);
    endtask

    task automatic do_clear();
        drive_cycle(0, '0, 0, '0, '0, 1, 0, 0, '0);
    endtask

    task automatic do_snap();
        drive_cycle(0, '0, 0, '0, '0, 0, 1, 0, '0);
    endtask

    task automatic read_sel(input logic [2:0] sel);
        drive_cycle(0, '0, 0, '0, '0, 0, 0, 1, sel);
    endtask

    task automatic do_reset();
        reset_n = 0;
        drive_cycle(0, '0, 0, '0, '0, 0, 0, 0, '0);
        idle();
        model_reset();
        reset_n = 1;
        idle();
    endtask

    task automatic goal_stream();
        retire(I_LOAD, 4'hF, 4'h0, 0);
        retire(I_STORE, 4'h0, 4'hF, 0);
        retire(I_COMPR, 4'h0, 4'h0, 0);
        retire(I_LOAD, 4'hF, 4'h0, 0);
        retire(I_STORE, 4'h0, 4'hF, 0);
        retire(I_COMPR, 4'h0, 4'h0, 0);
    endtask

    task automatic test_reset();
        reset_n = 0;
        rvfi_valid = 0; rvfi_insn = '0; rvfi_trap = 0; rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;
        clear = 0; snap = 0; rd_req = 0; rd_sel = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rd_ack !== 1'b0 || rd_data !== 16'd0 || goal_hit !== 1'b0)
            $display("FAIL reset_outputs: ack=%b data=%0d goal=%b expected 0/0/0", rd_ack, rd_data, goal_hit);
        else passed++;
        reset_n = 1;
        idle();
        do_snap();
        for (int i = 0; i < 6; i++) begin
            read_sel(3'(i));
            checks++;
            if (rd_ack !== 1'b1 || rd_data !== 16'd0)
                $display("FAIL reset_cnt[%0d]: ack=%b data=%0d expected ack=1 data=0", i, rd_ack, rd_data);
            else passed++;
        end
    endtask

    task automatic test_basic();
        int unsigned exp[6] = '{3, 1, 1, 2, 1, 0};
        do_reset();
        retire(I_LOAD, 4'hF, 4'h0, 0);
        retire(I_STORE, 4'h0, 4'hF, 0);
        retire(I_COMPR, 4'h0, 4'h0, 0);
        do_snap();
        for (int i = 0; i < 6; i++) begin
            read_sel(3'(i));
            checks++;
            if (rd_ack !== 1'b1 || rd_data !== 16'(exp[i]))
                $display("FAIL basic_cnt[%0d]: ack=%b data=%0d expected ack=1 data=%0d", i, rd_ack, rd_data, exp[i]);
            else passed++;
        end
        checks++;
        if (goal_hit !== 1'b0) $display("FAIL basic_goal: got %b expected 0", goal_hit);
        else passed++;
    endtask

    task automatic test_goal();
        do_clear();
        goal_stream();
        checks++;
        if (goal_hit !== 1'b0) $display("FAIL goal_early: got %b expected 0", goal_hit);
        else passed++;
        idle();
        checks++;
        if (goal_hit !== 1'b1 || goal_hit4 !== 1'b1)
            $display("FAIL goal_rise: got %b/%b expected 1/1", goal_hit, goal_hit4);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            idle();
            checks++;
            if (goal_hit !== 1'b1) $display("FAIL goal_sticky[%0d]: got %b expected 1", i, goal_hit);
            else passed++;
        end
    endtask

    task automatic test_trap();
        do_clear();
        retire(I_LOAD, 4'hF, 4'h0, 1);
        do_snap();
        read_sel(3'(TRAP));
        checks++;
        if (rd_data !== 16'd1) $display("FAIL trap_trap: got %0d expected 1", rd_data);
        else passed++;
        read_sel(3'(TOTAL));
        checks++;
        if (rd_data !== 16'd1) $display("FAIL trap_total: got %0d expected 1", rd_data);
        else passed++;
        read_sel(3'(DMEMRD));
        checks++;
        if (rd_data !== 16'd0) $display("FAIL trap_dmemrd: got %0d expected 0", rd_data);
        else passed++;
    endtask

    task automatic test_saturate();
        do_clear();
        for (int i = 0; i < 20; i++) retire(I_ADDI, 4'h0, 4'h0, 0);
        do_snap();
        read_sel(3'(LONG));
        checks++;
        if (rd_data4 !== 4'd15 || rd_data !== 16'd20)
            $display("FAIL sat_long: got %0d/%0d expected 15/20", rd_data4, rd_data);
        else passed++;
        read_sel(3'(TOTAL));
        checks++;
        if (rd_data4 !== 4'd15 || rd_data !== 16'd20)
            $display("FAIL sat_total: got %0d/%0d expected 15/20", rd_data4, rd_data);
        else passed++;
    endtask

    task automatic test_clear();
        do_clear();
        goal_stream();
        idle();
        do_snap();
        checks++;
        if (goal_hit !== 1'b1) $display("FAIL clear_pre_goal: got %b expected 1", goal_hit);
        else passed++;
        // clear + snap + valid store in one cycle
        drive_cycle(1, I_STORE, 0, 4'h0, 4'hF, 1, 1, 0, '0);
        checks++;
        if (goal_hit !== 1'b0) $display("FAIL clear_goal: got %b expected 0", goal_hit);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            read_sel(3'(i));
            checks++;
            if (rd_ack !== 1'b1 || rd_data !== 16'd0)
                $display("FAIL clear_snap[%0d]: ack=%b data=%0d expected ack=1 data=0", i, rd_ack, rd_data);
            else passed++;
        end
        do_snap();
        read_sel(3'(DMEMWR));
        checks++;
        if (rd_data !== 16'd0) $display("FAIL clear_dmemwr: got %0d expected 0", rd_data);
        else passed++;
        read_sel(3'(TOTAL));
        checks++;
        if (rd_data !== 16'd0) $display("FAIL clear_total: got %0d expected 0", rd_data);
        else passed++;
        read_sel(3'd7);
        checks++;
        if (rd_ack !== 1'b1 || rd_data !== 16'd0)
            $display("FAIL clear_sel7: ack=%b data=%0d expected ack=1 data=0", rd_ack, rd_data);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int unsigned pre;
        do_clear();
        retire(I_LOAD, 4'hF, 4'h0, 0);
        retire(I_COMPR, 4'h0, 4'h0, 0);
        do_snap();
        pre = m_snap[TOTAL];
        retire(I_STORE, 4'h0, 4'hF, 0);
        retire(I_STORE, 4'h3, 4'h3, 0);
        // read coincident with snap returns the pre-snap value
        drive_cycle(0, '0, 0, '0, '0, 0, 1, 1, 3'(TOTAL));
        checks++;
        if (rd_ack !== 1'b1 || rd_data !== 16'(pre))
            $display("FAIL b2b_presnap: ack=%b data=%0d expected ack=1 data=%0d", rd_ack, rd_data, pre);
        else passed++;
        for (int i = 7; i >= 0; i--) begin
            read_sel(3'(i));
            checks++;
            if (rd_ack !== 1'b1 || rd_data !== 16'(m_rd))
                $display("FAIL b2b_read[%0d]: ack=%b data=%0d expected ack=1 data=%0d", i, rd_ack, rd_data, m_rd);
            else passed++;
        end
        idle();
        checks++;
        if (rd_ack !== 1'b0 || rd_data !== 16'(m_rd))
            $display("FAIL b2b_hold: ack=%b data=%0d expected ack=0 data=%0d", rd_ack, rd_data, m_rd);
        else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bit          v    = ($urandom_range(0, 3) != 0);
            logic [31:0] insn = $urandom;
            bit          trap = ($urandom_range(0, 7) == 0);
            logic [3:0]  rm   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            logic [3:0]  wm   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            bit          clr  = ($urandom_range(0, 59) == 0);
            bit          snp  = ($urandom_range(0, 9) == 0);
            bit          rq   = $urandom_range(0, 1) == 1;
            logic [2:0]  sel  = 3'($urandom_range(0, 7));
            drive_cycle(v, insn, trap, rm, wm, clr, snp, rq, sel);
            checks++;
            if (rd_ack !== m_ack || rd_ack4 !== m_ack)
                $display("FAIL rnd_ack[%0d]: got %b/%b expected %b", n, rd_ack, rd_ack4, m_ack);
            else passed++;
            checks++;
            if (rd_data !== 16'(sat(m_rd, 16)))
                $display("FAIL rnd_data[%0d]: got %0d expected %0d", n, rd_data, sat(m_rd, 16));
            else passed++;
            checks++;
            if (rd_data4 !== 4'(sat(m_rd, 4)))
                $display("FAIL rnd_data4[%0d]: got %0d expected %0d", n, rd_data4, sat(m_rd, 4));
            else passed++;
            checks++;
            if (goal_hit !== m_goal || goal_hit4 !== m_goal)
                $display("FAIL rnd_goal[%0d]: got %b/%b expected %b", n, goal_hit, goal_hit4, m_goal);
            else passed++;
        end
    endtask

    task automatic test_reset_midread();
        do_clear();
        goal_stream();
        idle();
        do_snap();
        read_sel(3'(TOTAL));
        checks++;
        if (rd_data !== 16'd6) $display("FAIL rst_pre_total: got %0d expected 6", rd_data);
        else passed++;
        rvfi_valid = 1; rvfi_insn = I_LOAD; rvfi_mem_rmask = 4'hF;
        rd_req = 1; rd_sel = 3'(TOTAL);
        #2 reset_n = 0;
        #1;
        checks++;
        if (rd_ack !== 1'b0 || rd_data !== 16'd0 || goal_hit !== 1'b0)
            $display("FAIL rst_async: ack=%b data=%0d goal=%b expected 0/0/0", rd_ack, rd_data, goal_hit);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_ack !== 1'b0 || rd_data !== 16'd0)
            $display("FAIL rst_hold: ack=%b data=%0d expected 0/0", rd_ack, rd_data);
        else passed++;
        model_reset();
        rvfi_valid = 0; rvfi_mem_rmask = '0; rd_req = 0;
        reset_n = 1;
        idle();
        checks++;
        if (rd_ack !== 1'b0 || goal_hit !== 1'b0)
            $display("FAIL rst_after: ack=%b goal=%b expected 0/0", rd_ack, goal_hit);
        else passed++;
        do_snap();
        for (int i = 0; i < 6; i++) begin
            read_sel(3'(i));
            checks++;
            if (rd_ack !== 1'b1 || rd_data !== 16'd0)
                $display("FAIL rst_cnt[%0d]: ack=%b data=%0d expected ack=1 data=0", i, rd_ack, rd_data);
            else passed++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_goal();
        test_trap();
        test_saturate();
        test_clear();
        test_back_to_back();
        test_random();
        test_reset_midread();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
